regfile_mp: RTL

- Parametrised multi-port register file. It is the next-generation register file for the pipelined CPU datapath.
- It provides NUM_RD read ports and two write ports (WB and a second retire path).
- It includes an optional write-to-read bypass and an optional hardwired zero register.
- It adds a per-register busy scoreboard that hazard logic uses to stall dependent instructions.

---
 rtl/regfile_mp.sv | 83 ++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, optional write-first bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [1:0]               wr_en_i,
   input  logic [2*ADDR_W-1:0]      wr_addr_i,
   input  logic [2*DATA_W-1:0]      wr_data_i,
   input  logic [1:0]               wr_clr_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   output logic                     any_busy_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [1:0]        we;
   logic [ADDR_W-1:0] wa [2];
   logic [DATA_W-1:0] wd [2];
   logic [ADDR_W-1:0] ra;

   // Effective write enables: dropped during reset (keeps bypass quiet) and for a hardwired r0
   always_comb begin
      for (int j = 0; j < 2; j++) begin
         wa[j] = wr_addr_i[j*ADDR_W +: ADDR_W];
         wd[j] = wr_data_i[j*DATA_W +: DATA_W];
         we[j] = rst_n_i & wr_en_i[j] & ((ZERO_REG == 0) || (wa[j] != '0));
      end
   end

   // Port 1 is applied last so it wins on a shared address; a reserve overrides any clear
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < 2; j++) begin
         if (we[j]) begin
            regs_d[wa[j]] = wd[j];
            busy_d[wa[j]] = wr_clr_i[j] ? 1'b0 : busy_q[wa[j]];
         end
      end
      if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      ra        = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = rd_addr_i[k*ADDR_W +: ADDR_W];
         rd_data_o[k*DATA_W +: DATA_W] = regs_q[ra];
         if (BYPASS != 0) begin
            if (we[0] && wa[0] == ra) rd_data_o[k*DATA_W +: DATA_W] = wd[0];
            if (we[1] && wa[1] == ra) rd_data_o[k*DATA_W +: DATA_W] = wd[1];
         end
         if (ZERO_REG != 0 && ra == '0) rd_data_o[k*DATA_W +: DATA_W] = '0;
         rd_busy_o[k] = busy_q[ra];
      end
   end

   assign any_busy_o = |busy_q;
endmodule
